sha256_msg_padder: RTL and testbench

- Upstream feeder for the SHA-256 compression stage.
- Reads an NUM_OF_WORDS-word message from word-addressed synchronous memory starting at message_addr.
- Applies standard SHA-256 padding and presents 512-bit blocks one at a time on a valid/ready interface.
- The compression stage consumes block_data directly instead of fetching and padding the message itself.

---
 rtl/sha256_pkg.sv | 41 ++++
 rtl/sha256_msg_padder.sv | 140 ++++++++++++++
 tb/tb_sha256_msg_padder.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: widths, padder FSM states, block-count and
// pad-word helpers, plus the round constants used by the compression stage.
package sha256_pkg;

  localparam int          BLOCK_W  = 512;
  localparam int          WORD_W   = 32;
  localparam logic [31:0] PAD_WORD = 32'h8000_0000;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_PAD, ST_EMIT} state_e;

  localparam logic [31:0] SHA256_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] SHA256_H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Blocks needed for the message plus the 0x80 marker word and two length words.
  function automatic int num_blocks(input int words);
    return (words + 3 + 15) / 16;
  endfunction

  // Padding word for global word index g (only meaningful for g >= words).
  // The length high word is always zero since 32*1000 < 2^32.
  function automatic logic [31:0] pad_word(input logic [15:0] g, input int words);
    int gi = int'(g);
    if (gi == words) return PAD_WORD;
    if (gi == 16 * num_blocks(words) - 1) return 32'(32 * words);
    return '0;
  endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// Fetches a fixed-length message from word memory, applies SHA-256 padding
// and hands out one 512-bit block at a time over valid/ready.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [15:0]        message_addr,
  output logic [15:0]        mem_addr,
  output logic               mem_we,
  input  logic [WORD_W-1:0]  mem_read_data,
  output logic               block_valid,
  input  logic               block_ready,
  output logic [BLOCK_W-1:0] block_data,
  output logic               block_last,
  output logic               done
);

  localparam int NUM_BLOCKS = num_blocks(NUM_OF_WORDS);

  state_e                  state_q, state_d;
  logic [15:0]             base_q, base_d;
  logic [15:0]             addr_q, addr_d;
  logic [11:0]             blk_q, blk_d;
  logic [4:0]              cnt_q, cnt_d;
  logic                    vld_q, vld_d;
  logic                    last_q, last_d;
  logic [15:0][WORD_W-1:0] wbuf_q;
  logic [4:0]              k;
  logic                    last_blk;
  int                      rem;

  assign mem_addr    = addr_q;
  assign mem_we      = 1'b0;
  assign block_valid = vld_q;
  assign block_last  = last_q;
  assign done        = (state_q == ST_IDLE);
  assign last_blk    = (int'(blk_q) == NUM_BLOCKS - 1);

  // Message words carried by the current block, clamped to 0..16.
  always_comb begin
    rem = NUM_OF_WORDS - 16 * int'(blk_q);
    if (rem >= 16)     k = 5'd16;
    else if (rem <= 0) k = 5'd0;
    else               k = 5'(rem);
  end

  // Word 0 sits in the top 32 bits of the block.
  always_comb begin
    block_data = '0;
    for (int w = 0; w < 16; w++) block_data[BLOCK_W-1-32*w -: 32] = wbuf_q[w];
  end

  // Next-state logic: fetch k words (k+1 cycles incl. read latency), pad, emit.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    addr_d  = addr_q;
    blk_d   = blk_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: if (start) begin
        base_d  = message_addr;
        addr_d  = message_addr;
        blk_d   = '0;
        cnt_d   = '0;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (cnt_q == k) begin
          cnt_d   = '0;
          state_d = ST_PAD;
        end else begin
          cnt_d = cnt_q + 5'd1;
          // Keep the last issued address on the bus rather than running past it.
          if (cnt_q + 5'd1 < k) addr_d = addr_q + 16'd1;
        end
      end
      ST_PAD: begin
        vld_d   = 1'b1;
        last_d  = last_blk;
        state_d = ST_EMIT;
      end
      ST_EMIT: if (block_ready) begin
        vld_d  = 1'b0;
        last_d = 1'b0;
        if (last_q) begin
          state_d = ST_IDLE;
        end else begin
          blk_d   = blk_q + 12'd1;
          addr_d  = base_q + {blk_q + 12'd1, 4'd0};
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      blk_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      blk_q   <= blk_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end

  // Block buffer: capture read data one cycle behind each address, then
  // overwrite every word past the message end with its padding value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbuf_q <= '0;
    end else if (state_q == ST_FETCH && cnt_q != 5'd0) begin
      wbuf_q[4'(cnt_q - 5'd1)] <= mem_read_data;
    end else if (state_q == ST_PAD) begin
      for (int n = 0; n < 16; n++) begin
        if ({blk_q, 4'(n)} >= 16'(NUM_OF_WORDS))
          wbuf_q[n] <= pad_word({blk_q, 4'(n)}, NUM_OF_WORDS);
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench: three padders (N=20, 13, 16) share one message memory.
// Expected blocks come from a word-list padding model pushed at start
// acceptance; per-DUT monitors pop and compare on every valid cycle.
module tb_sha256_msg_padder;

  typedef struct {
    logic [511:0] data;
    logic         last;
    int           lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start [3];
  logic [15:0] saddr [3];
  logic        rdy   [3];
  int          rmode [3];
  logic [15:0] maddr [3];
  logic        we    [3];
  logic [31:0] rdat  [3];
  logic        vld   [3];
  logic [511:0] bdata [3];
  logic        lst   [3];
  logic        done  [3];
  logic [31:0] mem [65536];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nwords(input int i);
    return (i == 0) ? 20 : (i == 1) ? 13 : 16;
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int N = (gi == 0) ? 20 : (gi == 1) ? 13 : 16;
    exp_t        exp_q [$];
    int          ev_edge;
    int          hc;
    logic        prev_v, pend, pend_last;
    logic [15:0] hold_addr;

    sha256_msg_padder #(.NUM_OF_WORDS(N)) dut (
      .clk          (clk),
      .reset        (rst),
      .start        (start[gi]),
      .message_addr (saddr[gi]),
      .mem_addr     (maddr[gi]),
      .mem_we       (we[gi]),
      .mem_read_data(rdat[gi]),
      .block_valid  (vld[gi]),
      .block_ready  (rdy[gi]),
      .block_data   (bdata[gi]),
      .block_last   (lst[gi]),
      .done         (done[gi])
    );

    always @(posedge clk) rdat[gi] <= mem[maddr[gi]];

    // Ready driver: 0 = always ready, 1 = random, 2 = stall 10 valid cycles.
    initial begin
      rdy[gi] = 1'b1;
      hc = 0;
      forever begin
        @(posedge clk); #1;
        if (rmode[gi] == 2) begin
          if (vld[gi]) begin rdy[gi] = (hc >= 10); hc++; end
          else begin rdy[gi] = 1'b0; hc = 0; end
        end else if (rmode[gi] == 1) rdy[gi] = 1'($urandom % 2);
        else rdy[gi] = 1'b1;
      end
    end

    // Reference: message words, 0x80000000, zeros to 14 mod 16, then 64-bit length.
    function automatic void expect_msg(input logic [15:0] base);
      logic [31:0] w [$];
      exp_t e;
      int nb, kk;
      for (int j = 0; j < N; j++) w.push_back(mem[base + 16'(j)]);
      w.push_back(32'h8000_0000);
      while (w.size() % 16 != 14) w.push_back(32'h0);
      w.push_back(32'h0);
      w.push_back(32'(32 * N));
      nb = w.size() / 16;
      for (int b = 0; b < nb; b++) begin
        e.data = '0;
        for (int x = 0; x < 16; x++) e.data[511-32*x -: 32] = w[16*b+x];
        e.last = (b == nb - 1);
        kk = N - 16 * b;
        if (kk > 16) kk = 16;
        if (kk < 0) kk = 0;
        e.lat = kk + 2;
        exp_q.push_back(e);
      end
    endfunction

    // Monitor: compare every valid cycle, pop on handshake.
    always @(negedge clk) begin
      if (rst) begin
        exp_q.delete();
        prev_v = 1'b0;
        pend = 1'b0;
        pend_last = 1'b0;
      end else begin
        if (pend) begin
          chk($sformatf("d%0d valid_drop", gi), 512'(vld[gi]), 512'd0);
          if (pend_last) chk($sformatf("d%0d done_rise", gi), 512'(done[gi]), 512'd1);
          pend = 1'b0;
        end
        if (vld[gi]) begin
          chk($sformatf("d%0d block_expected", gi), 512'(exp_q.size() != 0), 512'd1);
          if (exp_q.size() != 0) begin
            if (!prev_v) begin
              chk($sformatf("d%0d latency", gi), 512'(cyc - ev_edge), 512'(exp_q[0].lat));
              hold_addr = maddr[gi];
            end
            chk($sformatf("d%0d data", gi), bdata[gi], exp_q[0].data);
            chk($sformatf("d%0d last", gi), 512'(lst[gi]), 512'(exp_q[0].last));
            chk($sformatf("d%0d addr_hold", gi), 512'(maddr[gi]), 512'(hold_addr));
            chk($sformatf("d%0d done_low", gi), 512'(done[gi]), 512'd0);
            if (rdy[gi]) begin
              pend = 1'b1;
              pend_last = exp_q[0].last;
              ev_edge = cyc + 1;
              void'(exp_q.pop_front());
              if (pend_last) chk($sformatf("d%0d leftover", gi), 512'(exp_q.size()), 512'd0);
            end
          end
        end
        if (done[gi] && start[gi]) begin
          expect_msg(saddr[gi]);
          ev_edge = cyc + 1;
        end
        prev_v = vld[gi];
      end
    end
  end

  task automatic fill(input logic [15:0] b, input int n, input bit rnd);
    for (int j = 0; j < n; j++) mem[b + 16'(j)] = rnd ? $urandom : 32'(j);
  endtask

  task automatic go(input int i, input logic [15:0] a);
    start[i] = 1'b1;
    saddr[i] = a;
    @(posedge clk); #1;
    start[i] = 1'b0;
  endtask

  task automatic stray(input int i);
    start[i] = 1'b1;
    saddr[i] = 16'h7777;
    @(posedge clk); #1;
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    int c = 0;
    while (!done[i] && c < 4000) begin @(posedge clk); #1; c++; end
    chk($sformatf("d%0d finish", i), 512'(done[i]), 512'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    int i;
    logic [15:0] b;
    rst = 1'b1;
    for (int j = 0; j < 3; j++) begin start[j] = 1'b0; saddr[j] = '0; rmode[j] = 0; end
    repeat (3) @(posedge clk);
    #1;
    for (int j = 0; j < 3; j++) begin
      chk("reset valid", 512'(vld[j]), 512'd0);
      chk("reset last", 512'(lst[j]), 512'd0);
      chk("reset done", 512'(done[j]), 512'd1);
      chk("reset mem_addr", 512'(maddr[j]), 512'd0);
      chk("reset data", bdata[j], 512'd0);
      chk("mem_we", 512'(we[j]), 512'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed: default two-block, single block, padding-only block.
    fill(16'h0000, 20, 0); go(0, 16'h0000); wait_done(0);
    fill(16'h0040, 13, 0); go(1, 16'h0040); wait_done(1);
    fill(16'h0200, 16, 0); go(2, 16'h0200); wait_done(2);

    // Backpressure: 10 stalled cycles per block.
    rmode[0] = 2;
    fill(16'h0300, 20, 1); go(0, 16'h0300); wait_done(0);
    rmode[0] = 0;

    // Reset during FETCH of block 1, then replay the default message.
    fill(16'h0000, 20, 0); go(0, 16'h0000);
    c = 0;
    while (!(vld[0] && rdy[0]) && c < 100) begin @(posedge clk); #1; c++; end
    chk("d0 handshake_wait", 512'(vld[0] && rdy[0]), 512'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midreset valid", 512'(vld[0]), 512'd0);
    chk("midreset done", 512'(done[0]), 512'd1);
    chk("midreset mem_addr", 512'(maddr[0]), 512'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    go(0, 16'h0000); wait_done(0);

    // Stray starts while busy must be ignored.
    rmode[0] = 1;
    fill(16'h0500, 20, 1); fill(16'h7777, 20, 1);
    go(0, 16'h0500);
    repeat (4) @(posedge clk);
    #1;
    stray(0);
    c = 0;
    while (!vld[0] && c < 100) begin @(posedge clk); #1; c++; end
    stray(0);
    wait_done(0);
    rmode[0] = 0;
    fill(16'h0100, 20, 1); go(0, 16'h0100); wait_done(0);

    // Random messages, bases (first one wraps past 0xFFFF) and ready patterns.
    for (int t = 0; t < 8; t++) begin
      i = $urandom_range(0, 2);
      b = (t == 0) ? 16'hFFF8 : 16'($urandom);
      rmode[i] = $urandom_range(0, 2);
      fill(b, nwords(i), 1);
      go(i, b);
      wait_done(i);
      rmode[i] = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
